vga_scan_driver: RTL

- Produces the pixelX/pixelY scan coordinates that every screen renderer (screen_end, screen_start, game screens) consumes, and takes the 8-bit RGB those renderers return.
- Generates VGA hsync/vsync, delays them to align with renderer latency, and drives the 4-4-4 DAC pins.
- Sits at the top level between the screen multiplexer and the board VGA connector.

---
 rtl/vga_scan_driver_pkg.sv | 39 +++
 rtl/vga_scan_driver_if.sv | 26 ++
 rtl/vga_scan_driver_pipe_delay.sv | 33 +++
 rtl/vga_scan_driver.sv | 118 +++++++++++
 4 files changed

// File: rtl/vga_scan_driver_pkg.sv
// rtl/vga_scan_driver_pkg.sv - VGA 640x480 timing constants, RGB332 layout and colour helpers
package vga_scan_driver_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int COORD_W = 11;
  localparam int RGB_W   = 8;
  localparam int DAC_W   = 4;

  localparam int RGB_R_MSB = 7;
  localparam int RGB_R_LSB = 5;
  localparam int RGB_G_MSB = 4;
  localparam int RGB_G_LSB = 2;
  localparam int RGB_B_MSB = 1;
  localparam int RGB_B_LSB = 0;

  localparam logic [RGB_W-1:0] COLOR_BLACK = 8'h00;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } timing_t;

  // 3-bit channel to 4-bit DAC: repeat the MSB so full scale maps to full scale
  function automatic logic [DAC_W-1:0] expand3(input logic [2:0] c);
    return {c, c[2]};
  endfunction

endpackage

// File: rtl/vga_scan_driver_if.sv
// rtl/vga_scan_driver_if.sv - renderer-facing scan bus and VGA pins of the scan driver
interface vga_scan_driver_if;
  import vga_scan_driver_pkg::*;

  logic               pix_en;
  logic [RGB_W-1:0]   RGB_in;
  logic [COORD_W-1:0] pixelX;
  logic [COORD_W-1:0] pixelY;
  logic               frame_start;
  logic               vga_hs;
  logic               vga_vs;
  logic [DAC_W-1:0]   vga_r;
  logic [DAC_W-1:0]   vga_g;
  logic [DAC_W-1:0]   vga_b;

  modport master (
    input  pix_en, RGB_in,
    output pixelX, pixelY, frame_start, vga_hs, vga_vs, vga_r, vga_g, vga_b
  );

  modport slave (
    output pix_en, RGB_in,
    input  pixelX, pixelY, frame_start, vga_hs, vga_vs, vga_r, vga_g, vga_b
  );

endinterface

// File: rtl/vga_scan_driver_pipe_delay.sv
// rtl/vga_scan_driver_pipe_delay.sv - enable-gated shift register; DEPTH=0 is a plain wire
module vga_scan_driver_pipe_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else if (en) begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_driver.sv
// rtl/vga_scan_driver.sv - VGA scan counters, sync generation aligned to renderer latency, RGB332 to 4-4-4 DAC
module vga_scan_driver
  import vga_scan_driver_pkg::*;
#(
  parameter int H_ACTIVE        = vga_scan_driver_pkg::H_ACTIVE,
  parameter int H_FP            = vga_scan_driver_pkg::H_FP,
  parameter int H_SYNC          = vga_scan_driver_pkg::H_SYNC,
  parameter int H_BP            = vga_scan_driver_pkg::H_BP,
  parameter int V_ACTIVE        = vga_scan_driver_pkg::V_ACTIVE,
  parameter int V_FP            = vga_scan_driver_pkg::V_FP,
  parameter int V_SYNC          = vga_scan_driver_pkg::V_SYNC,
  parameter int V_BP            = vga_scan_driver_pkg::V_BP,
  parameter int PIPE_DELAY      = 1,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  vga_scan_driver_if.master  bus
);

  localparam int HTOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(HTOT - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(VTOT - 1);
  localparam logic [COORD_W-1:0] X_ACT  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] Y_ACT  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               fs_q;
  logic               x_last;
  logic               y_last;

  assign x_last = (x_q == X_LAST);
  assign y_last = (y_q == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q  <= '0;
      y_q  <= '0;
      fs_q <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      if (bus.pix_en) begin
        fs_q <= x_last && y_last;
        if (x_last) begin
          x_q <= '0;
          y_q <= y_last ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  timing_t raw_t;
  timing_t dly_t;

  always_comb begin
    raw_t     = '0;
    raw_t.hs  = (x_q >= HS_BEG) && (x_q < HS_END);
    raw_t.vs  = (y_q >= VS_BEG) && (y_q < VS_END);
    raw_t.act = (x_q < X_ACT) && (y_q < Y_ACT);
  end

  // Delay line matches the renderer's latency so syncs and blanking line up with RGB_in
  vga_scan_driver_pipe_delay #(
    .WIDTH     ($bits(timing_t)),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL ('0)
  ) u_pipe (
    .clk   (clk),
    .reset (reset),
    .en    (bus.pix_en),
    .d     (raw_t),
    .q     (dly_t)
  );

  logic [RGB_W-1:0] pix_c;
  logic             hs_q;
  logic             vs_q;
  logic [DAC_W-1:0] r_q;
  logic [DAC_W-1:0] g_q;
  logic [DAC_W-1:0] b_q;

  assign pix_c = dly_t.act ? bus.RGB_in : COLOR_BLACK;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q <= SYNC_ACTIVE_LOW;
      vs_q <= SYNC_ACTIVE_LOW;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else if (bus.pix_en) begin
      hs_q <= dly_t.hs ^ SYNC_ACTIVE_LOW;
      vs_q <= dly_t.vs ^ SYNC_ACTIVE_LOW;
      r_q  <= expand3(pix_c[RGB_R_MSB:RGB_R_LSB]);
      g_q  <= expand3(pix_c[RGB_G_MSB:RGB_G_LSB]);
      b_q  <= {pix_c[RGB_B_MSB:RGB_B_LSB], pix_c[RGB_B_MSB:RGB_B_LSB]};
    end
  end

  assign bus.pixelX      = x_q;
  assign bus.pixelY      = y_q;
  assign bus.frame_start = fs_q;
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_r       = r_q;
  assign bus.vga_g       = g_q;
  assign bus.vga_b       = b_q;

endmodule
